lcd_fill: RTL and testbench

LCD_FILL -- requirements
Module: lcd_fill

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_bus_wr.sv | 56 +++++
 rtl/lcd_fill.sv | 175 +++++++++++++++++
 tb/tb_lcd_fill.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD rectangle-fill engine: CPU register map,
// panel command bytes, master offsets, FSM states and the window command sequence.
package lcd_pkg;

    localparam logic [3:0] REG_XWIN  = 4'h0;
    localparam logic [3:0] REG_YWIN  = 4'h4;
    localparam logic [3:0] REG_COLOR = 4'h8;
    localparam logic [3:0] REG_CTRL  = 4'hC;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [7:0] MOFF_CMD = 8'h00;
    localparam logic [7:0] MOFF_PIX = 8'h04;

    localparam logic [3:0] LAST_CMD_IDX = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_PIX  = 2'd2,
        ST_FIN  = 2'd3
    } fill_state_e;

    // {rs, byte} for word idx of the window setup; rs=0 marks a command byte.
    function automatic logic [8:0] cmd_word(input logic [3:0] idx,
                                            input logic [8:0] x0, input logic [8:0] x1,
                                            input logic [8:0] y0, input logic [8:0] y1);
        logic [8:0] w;
        case (idx)
            4'd0:    w = {1'b0, CMD_CASET};
            4'd1:    w = {1'b1, 7'b0, x0[8]};
            4'd2:    w = {1'b1, x0[7:0]};
            4'd3:    w = {1'b1, 7'b0, x1[8]};
            4'd4:    w = {1'b1, x1[7:0]};
            4'd5:    w = {1'b0, CMD_PASET};
            4'd6:    w = {1'b1, 7'b0, y0[8]};
            4'd7:    w = {1'b1, y0[7:0]};
            4'd8:    w = {1'b1, 7'b0, y1[8]};
            4'd9:    w = {1'b1, y1[7:0]};
            default: w = {1'b0, CMD_RAMWR};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lcd_bus_wr.sv
// Single-word master write: holds a word until m_ready, then drops m_valid
// for one cycle; the next request is taken in that idle cycle.
module lcd_bus_wr (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ack,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready
);

    logic        m_valid_q, m_valid_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;

    // m_ready is only meaningful while a word is outstanding
    assign ack = m_valid_q & m_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        if (m_valid_q) begin
            if (m_ready) begin
                m_valid_d = 1'b0;
            end
        end else if (req) begin
            m_valid_d = 1'b1;
            m_addr_d  = req_addr;
            m_wdata_d = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = {4{m_valid_q}};

endmodule

// File: rtl/lcd_fill.sv
// LCD rectangle fill: CPU-programmed window/colour, then streams the 11-word
// window setup and one pixel word per window pixel to the LCD controller.
module lcd_fill
    import lcd_pkg::*;
#(
    parameter logic [31:0] LCD_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb
);

    fill_state_e state_q, state_d;
    logic [3:0]  cmd_idx_q, cmd_idx_d;
    logic [17:0] pix_cnt_q, pix_cnt_d;
    logic [8:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [8:0]  lx0_q, lx0_d, lx1_q, lx1_d, ly0_q, ly0_d, ly1_q, ly1_d;
    logic [15:0] color_q, color_d, lcolor_q, lcolor_d;
    logic        done_q, done_d, err_q, err_d;
    logic        acc_q, acc_d, s_ready_q, s_ready_d;
    logic [31:0] s_rdata_q, s_rdata_d;

    logic        busy, start, bus_req, bus_ack;
    logic [31:0] rd_val, req_addr, req_wdata;
    logic [9:0]  win_w, win_h;
    logic [19:0] pix_total;
    logic        unused_bits;

    assign busy  = (state_q != ST_IDLE);
    assign start = acc_q && (s_addr[3:0] == REG_CTRL) && s_wstrb[0] && s_wdata[0];
    assign win_w = {1'b0, x1_q} - {1'b0, x0_q} + 10'd1;
    assign win_h = {1'b0, y1_q} - {1'b0, y0_q} + 10'd1;
    // Counter holds pixels-remaining minus one so a full 512x512 window fits in 18 bits
    assign pix_total   = {10'd0, win_w} * {10'd0, win_h} - 20'd1;
    assign unused_bits = ^{s_addr[31:4], s_wdata[31:25], pix_total[19:18]};

    always_comb begin
        case (s_addr[3:0])
            REG_XWIN:  rd_val = {7'b0, x1_q, 7'b0, x0_q};
            REG_YWIN:  rd_val = {7'b0, y1_q, 7'b0, y0_q};
            REG_COLOR: rd_val = {16'b0, color_q};
            REG_CTRL:  rd_val = {29'b0, err_q, done_q, busy};
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_idx_d = cmd_idx_q;
        pix_cnt_d = pix_cnt_q;
        x0_d = x0_q;  x1_d = x1_q;  y0_d = y0_q;  y1_d = y1_q;
        lx0_d = lx0_q; lx1_d = lx1_q; ly0_d = ly0_q; ly1_d = ly1_q;
        color_d   = color_q;
        lcolor_d  = lcolor_q;
        done_d    = done_q;
        err_d     = err_q;
        acc_d     = s_valid && !acc_q && !s_ready_q;
        s_ready_d = acc_q;
        s_rdata_d = '0;

        case (state_q)
            ST_CMD: if (bus_ack) begin
                if (cmd_idx_q == LAST_CMD_IDX) state_d = ST_PIX;
                else                           cmd_idx_d = cmd_idx_q + 4'd1;
            end
            ST_PIX: if (bus_ack) begin
                if (pix_cnt_q == '0) state_d = ST_FIN;
                else                 pix_cnt_d = pix_cnt_q - 18'd1;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: ;
        endcase

        if (acc_q) begin
            if (s_wstrb == 4'b0000) begin
                s_rdata_d = rd_val;
            end else if (!busy) begin
                case (s_addr[3:0])
                    REG_XWIN: begin
                        x0_d = {s_wstrb[1] ? s_wdata[8]  : x0_q[8], s_wstrb[0] ? s_wdata[7:0]   : x0_q[7:0]};
                        x1_d = {s_wstrb[3] ? s_wdata[24] : x1_q[8], s_wstrb[2] ? s_wdata[23:16] : x1_q[7:0]};
                    end
                    REG_YWIN: begin
                        y0_d = {s_wstrb[1] ? s_wdata[8]  : y0_q[8], s_wstrb[0] ? s_wdata[7:0]   : y0_q[7:0]};
                        y1_d = {s_wstrb[3] ? s_wdata[24] : y1_q[8], s_wstrb[2] ? s_wdata[23:16] : y1_q[7:0]};
                    end
                    REG_COLOR: begin
                        color_d = {s_wstrb[1] ? s_wdata[15:8] : color_q[15:8],
                                   s_wstrb[0] ? s_wdata[7:0]  : color_q[7:0]};
                    end
                    default: ;
                endcase
            end
        end

        if (start && !busy) begin
            done_d = 1'b0;
            if ((x1_q < x0_q) || (y1_q < y0_q)) begin
                err_d = 1'b1;
            end else begin
                err_d     = 1'b0;
                state_d   = ST_CMD;
                cmd_idx_d = '0;
                pix_cnt_d = pix_total[17:0];
                lx0_d = x0_q; lx1_d = x1_q; ly0_d = y0_q; ly1_d = y1_q;
                lcolor_d  = color_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cmd_idx_q <= '0;
            pix_cnt_q <= '0;
            x0_q <= '0;  x1_q <= '0;  y0_q <= '0;  y1_q <= '0;
            lx0_q <= '0; lx1_q <= '0; ly0_q <= '0; ly1_q <= '0;
            color_q   <= '0;
            lcolor_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= 1'b0;
            s_ready_q <= 1'b0;
            s_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_idx_q <= cmd_idx_d;
            pix_cnt_q <= pix_cnt_d;
            x0_q <= x0_d;  x1_q <= x1_d;  y0_q <= y0_d;  y1_q <= y1_d;
            lx0_q <= lx0_d; lx1_q <= lx1_d; ly0_q <= ly0_d; ly1_q <= ly1_d;
            color_q   <= color_d;
            lcolor_q  <= lcolor_d;
            done_q    <= done_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            s_ready_q <= s_ready_d;
            s_rdata_q <= s_rdata_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign s_rdata   = s_rdata_q;
    assign bus_req   = (state_q == ST_CMD) || (state_q == ST_PIX);
    assign req_addr  = {LCD_BASE[31:8], (state_q == ST_PIX) ? MOFF_PIX : MOFF_CMD};
    assign req_wdata = (state_q == ST_PIX) ? {16'b0, lcolor_q}
                                           : {23'b0, cmd_word(cmd_idx_q, lx0_q, lx1_q, ly0_q, ly1_q)};

    lcd_bus_wr u_bus_wr (
        .clk       (clk),
        .resetn    (resetn),
        .req       (bus_req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (bus_ack),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready)
    );

endmodule

// File: tb/tb_lcd_fill.sv
// Bench for lcd_fill: random windows and responder timing checked against a
// word-list model built straight from the window/colour rules.
module tb_lcd_fill;

    localparam logic [31:0] TB_BASE = 32'h4000_12FF;
    localparam logic [31:0] A_XWIN  = 32'h0;
    localparam logic [31:0] A_YWIN  = 32'h4;
    localparam logic [31:0] A_COLOR = 32'h8;
    localparam logic [31:0] A_CTRL  = 32'hC;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] s_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    int          words_seen = 0;
    int          valid_cycles = 0;
    bit          mon_en = 1'b0;
    bit          spurious_en = 1'b0;
    int          resp_max_delay = 0;

    always #5 clk = ~clk;

    lcd_fill #(.LCD_BASE(TB_BASE)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected master words for one fill: 11 setup words, then one word per pixel
    function automatic void push_fill(input int x0, input int x1, input int y0, input int y1,
                                      input logic [15:0] color);
        int          vals[11];
        logic [31:0] cmd_addr;
        logic [31:0] pix_addr;
        int          wd;
        cmd_addr = {TB_BASE[31:8], 8'h00};
        pix_addr = {TB_BASE[31:8], 8'h04};
        vals = '{32'h2A, x0 / 256, x0 % 256, x1 / 256, x1 % 256,
                 32'h2B, y0 / 256, y0 % 256, y1 / 256, y1 % 256, 32'h2C};
        for (int i = 0; i < 11; i++) begin
            wd = vals[i];
            if (i != 0 && i != 5 && i != 10) wd = wd + 256;
            exp_q.push_back({cmd_addr, 32'(wd)});
        end
        for (int n = 0; n < (x1 - x0 + 1) * (y1 - y0 + 1); n++)
            exp_q.push_back({pix_addr, 16'h0, color});
    endfunction

    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [63:0] prev_word = '0;
    int          gap_phase = 0;

    // Master-side monitor: word order/content, hold-until-ready, one idle cycle between words
    always @(negedge clk) begin
        logic        hs;
        logic [63:0] cur;
        hs  = m_valid && m_ready;
        cur = {m_addr, m_wdata};
        if (m_valid) valid_cycles++;
        if (!resetn || !mon_en) begin
            gap_phase  = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (gap_phase == 1) begin
                checkOutput("gap_low", 64'(m_valid), 64'd0);
                gap_phase = 2;
            end else if (gap_phase == 2) begin
                checkOutput("gap_rise", 64'(m_valid), 64'd1);
                gap_phase = 0;
            end
            if (prev_valid && !prev_hs) begin
                checkOutput("hold_valid", 64'(m_valid), 64'd1);
                checkOutput("hold_word", cur, prev_word);
            end
            if (hs) begin
                words_seen++;
                checkOutput("wstrb", 64'(m_wstrb), 64'hF);
                if (exp_q.size() != 0) begin
                    checkOutput("word", cur, exp_q.pop_front());
                    if (exp_q.size() != 0) gap_phase = 1;
                end
            end
            prev_valid = m_valid;
            prev_hs    = hs;
            prev_word  = cur;
        end
    end

    // LCD-controller responder with random latency and optional stray m_ready pulses
    initial begin
        int wait_cnt;
        int delay;
        m_ready  = 1'b0;
        wait_cnt = 0;
        delay    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                m_ready  = 1'b0;
                wait_cnt = 0;
            end else if (m_ready) begin
                m_ready  = 1'b0;
                wait_cnt = 0;
                delay    = $urandom_range(0, resp_max_delay);
            end else if (m_valid) begin
                if (wait_cnt >= delay) m_ready = 1'b1;
                else                   wait_cnt++;
            end else if (spurious_en && $urandom_range(0, 2) == 0) begin
                m_ready = 1'b1;
            end
        end
    end

    task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output logic [31:0] rdata);
        int k;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_addr  = addr;
        s_wdata = wdata;
        s_wstrb = wstrb;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 10) begin
            k++;
            @(negedge clk);
        end
        rdata = s_rdata;
        checkOutput("s_latency", 64'(k), 64'd2);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_wstrb = 4'b0000;
        @(negedge clk);
        checkOutput("s_ready_low", 64'(s_ready), 64'd0);
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        cpu_access(addr, data, 4'hF, dummy);
    endtask

    task automatic cpu_check_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        cpu_access(addr, 32'h0, 4'h0, r);
        checkOutput(tag, 64'(r), 64'(exp));
    endtask

    task automatic wait_fill(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        checkOutput("fill_drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_ctl"}, {31'b0, m_valid, m_wstrb, s_ready, m_addr}, 64'd0);
        checkOutput({tag, "_dat"}, {m_wdata, s_rdata}, 64'd0);
    endtask

    // One complete fill with the model, ending with word count and CTRL=done
    task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                                 input logic [15:0] color);
        int n;
        n = (x1 - x0 + 1) * (y1 - y0 + 1);
        cpu_write(A_XWIN, {7'b0, 9'(x1), 7'b0, 9'(x0)});
        cpu_write(A_YWIN, {7'b0, 9'(y1), 7'b0, 9'(y0)});
        cpu_write(A_COLOR, {16'h0, color});
        words_seen = 0;
        push_fill(x0, x1, y0, y1, color);
        mon_en = 1'b1;
        cpu_write(A_CTRL, 32'h1);
        wait_fill(n * (resp_max_delay + 4) + 200);
        repeat (5) @(posedge clk);
        checkOutput("word_count", 64'(words_seen), 64'(11 + n));
        cpu_check_read("ctrl_done", A_CTRL, 32'h2);
    endtask

    initial begin
        logic [31:0] rv;
        int          w, h, x0, y0, c;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst_out");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cpu_check_read("rst_ctrl", A_CTRL, 32'h0);
        cpu_check_read("rst_xwin", A_XWIN, 32'h0);
        cpu_check_read("rst_color", A_COLOR, 32'h0);

        for (int i = 0; i < 3; i++) begin
            rv = $urandom;
            cpu_write(A_XWIN, rv);
            cpu_check_read("xwin_rb", A_XWIN, rv & 32'h01FF_01FF);
            rv = $urandom;
            cpu_write(A_YWIN, rv);
            cpu_check_read("ywin_rb", A_YWIN, rv & 32'h01FF_01FF);
            rv = $urandom;
            cpu_write(A_COLOR, rv);
            cpu_check_read("color_rb", A_COLOR, rv & 32'h0000_FFFF);
        end
        cpu_write(A_XWIN, 32'h0123_0045);
        cpu_check_read("unmapped_rd", 32'h2, 32'h0);
        cpu_write(32'h3, 32'hFFFF_FFFF);
        cpu_check_read("unmapped_wr", A_XWIN, 32'h0123_0045);
        cpu_check_read("addr_alias", 32'h10, 32'h0123_0045);

        $display("[TB] 1x1 window");
        applyStimulus(5, 5, 7, 7, 16'($urandom));

        $display("[TB] inverted window start");
        cpu_write(A_XWIN, 32'h0004_0010);
        cpu_write(A_YWIN, 32'h0007_0002);
        valid_cycles = 0;
        cpu_write(A_CTRL, 32'h1);
        repeat (20) @(posedge clk);
        checkOutput("err_no_valid", 64'(valid_cycles), 64'd0);
        cpu_check_read("ctrl_err", A_CTRL, 32'h4);

        $display("[TB] random fills");
        applyStimulus(250, 257, 300, 302, 16'hF800);
        for (int i = 0; i < 6; i++) begin
            resp_max_delay = i % 4;
            spurious_en    = (i % 2) == 1;
            w  = $urandom_range(1, 8);
            h  = $urandom_range(1, 6);
            x0 = $urandom_range(0, 512 - w);
            y0 = $urandom_range(0, 512 - h);
            applyStimulus(x0, x0 + w - 1, y0, y0 + h - 1, 16'($urandom));
        end

        $display("[TB] writes and start during fill");
        resp_max_delay = 2;
        spurious_en    = 1'b0;
        cpu_write(A_XWIN, 32'h000F_000A);
        cpu_write(A_YWIN, 32'h0018_0014);
        cpu_write(A_COLOR, 32'h0000_07E0);
        words_seen = 0;
        push_fill(10, 15, 20, 24, 16'h07E0);
        cpu_write(A_CTRL, 32'h1);
        c = 0;
        while (words_seen < 16 && c < 500) begin
            @(posedge clk);
            c++;
        end
        checkOutput("reach_pix", 64'(words_seen >= 16), 64'd1);
        cpu_write(A_COLOR, 32'h0000_001F);
        cpu_write(A_XWIN, 32'h0020_0000);
        cpu_write(A_CTRL, 32'h1);
        cpu_check_read("ctrl_busy", A_CTRL, 32'h1);
        wait_fill(500);
        repeat (5) @(posedge clk);
        checkOutput("latch_count", 64'(words_seen), 64'(11 + 30));
        cpu_check_read("latch_ctrl", A_CTRL, 32'h2);
        cpu_check_read("latch_color", A_COLOR, 32'h0000_07E0);
        cpu_check_read("latch_xwin", A_XWIN, 32'h000F_000A);

        $display("[TB] reset during pixel 100");
        resp_max_delay = 1;
        cpu_write(A_XWIN, {7'b0, 9'd119, 7'b0, 9'd100});
        cpu_write(A_YWIN, {7'b0, 9'd9, 7'b0, 9'd0});
        words_seen = 0;
        push_fill(100, 119, 0, 9, 16'h1234);
        cpu_write(A_COLOR, 32'h0000_1234);
        cpu_write(A_CTRL, 32'h1);
        c = 0;
        while (words_seen < 110 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        c = 0;
        @(negedge clk);
        while (!m_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        checkOutput("pix100_pending", {31'b0, m_valid, 32'(words_seen)}, {31'b0, 1'b1, 32'd110});
        #2;
        mon_en = 1'b0;
        exp_q.delete();
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        valid_cycles = 0;
        repeat (50) @(negedge clk);
        checkOutput("post_rst_no_valid", 64'(valid_cycles), 64'd0);
        cpu_check_read("post_rst_ctrl", A_CTRL, 32'h0);
        cpu_check_read("post_rst_xwin", A_XWIN, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
